a2d_scan_intf: RTL and testbench

Parametrised multi-channel A2D scanner: SPI master toward the ADC128S converter that converts a masked set of channels in one scan command, pipelining each channel's command frame with the previous channel's result frame. It sits between the control logic and the `ADC128S` and supersedes the single-shot `A2D_intf`. Results go to a per-channel result register file and are also streamed with a valid strobe.

---
 rtl/a2d_pkg.sv | 42 ++++
 rtl/spi_mstr16.sv | 137 +++++++++++++
 rtl/a2d_scan_intf.sv | 194 +++++++++++++++++++
 tb/tb_a2d_scan_intf.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the multi-channel A2D scanner and its SPI frame engine.
package a2d_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CH_W       = 3;
    localparam int CH_MSB     = 13;
    localparam int CH_LSB     = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_XFER  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } scan_state_e;

    typedef enum logic [2:0] {
        SP_IDLE  = 3'd0,
        SP_FRONT = 3'd1,
        SP_SHIFT = 3'd2,
        SP_BACK  = 3'd3,
        SP_GAP   = 3'd4
    } spi_state_e;

    // Lowest set bit of an 8-bit channel mask; 0 when the mask is empty.
    function automatic logic [CH_W-1:0] first_ch(input logic [7:0] m);
        logic [CH_W-1:0] ch;
        ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            ch = m[i] ? CH_W'(i) : ch;
        end
        return ch;
    endfunction

    function automatic logic [FRAME_BITS-1:0] mk_cmd(input logic [CH_W-1:0] ch);
        logic [FRAME_BITS-1:0] f;
        f = 16'h0000;
        f[CH_MSB:CH_LSB] = ch;
        return f;
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master frame engine: SCLK idles high, MOSI changes on falling SCLK,
// MISO sampled on rising SCLK. A write during the inter-frame gap is held until the gap expires.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wrt,
    input  logic [FRAME_BITS-1:0] cmd,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int CW   = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    spi_state_e st_r, st_nxt_s;
    logic [CW-1:0]         cnt_r;
    logic [4:0]            edge_r;
    logic [FRAME_BITS-1:0] tx_r, rx_r, rd_data_r;
    logic                  ss_n_r, sclk_r, mosi_r, done_r, pend_r;
    logic                  tick_s, rising_s, last_rise_s, go_s;

    // Frame engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r <= SP_IDLE;
        end else begin
            st_r <= st_nxt_s;
        end
    end

    // Half-period tick and edge qualifiers.
    always_comb begin
        tick_s      = (cnt_r == HALF_M1);
        rising_s    = !sclk_r;
        last_rise_s = rising_s && (edge_r == 5'd30);
        go_s        = pend_r || wrt;
    end

    // Next-state logic: front porch, 31 SCLK edges after the first fall, back porch, gap.
    always_comb begin
        st_nxt_s = st_r;
        case (st_r)
            SP_IDLE:  st_nxt_s = wrt ? SP_FRONT : SP_IDLE;
            SP_FRONT: st_nxt_s = tick_s ? SP_SHIFT : SP_FRONT;
            SP_SHIFT: st_nxt_s = (tick_s && last_rise_s) ? SP_BACK : SP_SHIFT;
            SP_BACK:  st_nxt_s = tick_s ? SP_GAP : SP_BACK;
            SP_GAP:   st_nxt_s = tick_s ? (go_s ? SP_FRONT : SP_IDLE) : SP_GAP;
            default:  st_nxt_s = SP_IDLE;
        endcase
    end

    // Shift datapath and registered SPI pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            edge_r    <= 5'd0;
            tx_r      <= 16'h0000;
            rx_r      <= 16'h0000;
            rd_data_r <= 16'h0000;
            ss_n_r    <= 1'b1;
            sclk_r    <= 1'b1;
            mosi_r    <= 1'b0;
            done_r    <= 1'b0;
            pend_r    <= 1'b0;
        end else begin
            cnt_r  <= ((st_r == SP_IDLE) || tick_s) ? {CW{1'b0}} : (cnt_r + CNT_ONE);
            done_r <= 1'b0;
            case (st_r)
                SP_IDLE: begin
                    if (wrt) begin
                        tx_r   <= cmd;
                        ss_n_r <= 1'b0;
                    end
                end
                SP_FRONT: begin
                    if (tick_s) begin
                        sclk_r <= 1'b0;
                        mosi_r <= tx_r[15];
                        tx_r   <= {tx_r[14:0], 1'b0};
                        edge_r <= 5'd0;
                    end
                end
                SP_SHIFT: begin
                    if (tick_s) begin
                        edge_r <= edge_r + 5'd1;
                        if (rising_s) begin
                            sclk_r <= 1'b1;
                            rx_r   <= {rx_r[14:0], MISO};
                        end else begin
                            sclk_r <= 1'b0;
                            mosi_r <= tx_r[15];
                            tx_r   <= {tx_r[14:0], 1'b0};
                        end
                    end
                end
                SP_BACK: begin
                    if (tick_s) begin
                        ss_n_r    <= 1'b1;
                        done_r    <= 1'b1;
                        rd_data_r <= rx_r;
                        mosi_r    <= 1'b0;
                    end
                end
                SP_GAP: begin
                    if (wrt) begin
                        tx_r   <= cmd;
                        pend_r <= 1'b1;
                    end
                    if (tick_s) begin
                        ss_n_r <= !go_s;
                        pend_r <= 1'b0;
                    end
                end
                default: begin
                    ss_n_r <= 1'b1;
                end
            endcase
        end
    end

    assign done    = done_r;
    assign rd_data = rd_data_r;
    assign SS_n    = ss_n_r;
    assign SCLK    = sclk_r;
    assign MOSI    = mosi_r;

endmodule

// File: rtl/a2d_scan_intf.sv
// Multi-channel ADC128S scanner: each frame commands the next enabled channel while returning
// the previous one's result. Optional continuous mode via A2D_SCAN_CONT_EN.
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SCLK_DIV = 32,
    parameter int RES_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strt_scan,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              busy,
    output logic [RES_W-1:0]  res,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_vld,
    output logic              scan_done,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [RES_W-1:0]  rd_data,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
`ifdef A2D_SCAN_CONT_EN
    ,
    input  logic              cont
`endif
);

    scan_state_e state_r, state_nxt_s;
    logic [7:0]            mask_r, start_mask_s;
    logic [CH_W-1:0]       cmd_ch_r, cap_ch_r, launch_ch_s;
    logic                  launch_s, capture_s, load_mask_s, done_pulse_s, busy_nxt_s, cont_go_s;
    logic                  spi_done_s;
    logic [FRAME_BITS-1:0] spi_rd_s;
    logic                  unused_rd_s;
    logic                  busy_r, res_vld_r, scan_done_r;
    logic [RES_W-1:0]      res_r;
    logic [CH_W-1:0]       res_ch_r;
    logic [RES_W-1:0]      rf_r [NUM_CH];

`ifdef A2D_SCAN_CONT_EN
    assign cont_go_s = cont && (start_mask_s != 8'h00);
`else
    assign cont_go_s = 1'b0;
`endif
    assign unused_rd_s = ^(spi_rd_s >> RES_W);

    // Channel mask widened to 8 bits for the priority encoder.
    always_comb begin
        start_mask_s = 8'h00;
        start_mask_s[NUM_CH-1:0] = ch_mask;
    end

    // Scanner state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  state_nxt_s = (strt_scan && (start_mask_s != 8'h00)) ? S_CMD : S_IDLE;
            S_CMD,
            S_XFER:  state_nxt_s = spi_done_s ? ((mask_r != 8'h00) ? S_XFER : S_FLUSH) : state_r;
            S_FLUSH: state_nxt_s = spi_done_s ? S_DONE : S_FLUSH;
            S_DONE:  state_nxt_s = cont_go_s ? S_CMD : S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output/control decode; an empty mask after the last launch makes the ch=0 flush frame.
    always_comb begin
        launch_s     = 1'b0;
        launch_ch_s  = 3'd0;
        capture_s    = 1'b0;
        load_mask_s  = 1'b0;
        done_pulse_s = 1'b0;
        busy_nxt_s   = busy_r;
        case (state_r)
            S_IDLE: begin
                load_mask_s  = strt_scan && (start_mask_s != 8'h00);
                launch_s     = load_mask_s;
                launch_ch_s  = first_ch(start_mask_s);
                busy_nxt_s   = load_mask_s;
                done_pulse_s = strt_scan && (start_mask_s == 8'h00);
            end
            S_CMD: begin
                launch_s    = spi_done_s;
                launch_ch_s = first_ch(mask_r);
            end
            S_XFER: begin
                launch_s    = spi_done_s;
                launch_ch_s = first_ch(mask_r);
                capture_s   = spi_done_s;
            end
            S_FLUSH: begin
                capture_s = spi_done_s;
            end
            S_DONE: begin
                done_pulse_s = 1'b1;
                load_mask_s  = cont_go_s;
                launch_s     = cont_go_s;
                launch_ch_s  = first_ch(start_mask_s);
                busy_nxt_s   = cont_go_s;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Channel sequencing: remaining mask, channel in flight, channel whose result is returning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r   <= 8'h00;
            cmd_ch_r <= 3'd0;
            cap_ch_r <= 3'd0;
        end else begin
            if (load_mask_s) begin
                mask_r <= start_mask_s & ~(8'h01 << launch_ch_s);
            end else if (launch_s) begin
                mask_r <= mask_r & ~(8'h01 << launch_ch_s);
            end
            if (launch_s) begin
                cap_ch_r <= cmd_ch_r;
                cmd_ch_r <= launch_ch_s;
            end
        end
    end

    // Registered status outputs and result file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            res_vld_r   <= 1'b0;
            scan_done_r <= 1'b0;
            res_r       <= {RES_W{1'b0}};
            res_ch_r    <= 3'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                rf_r[i] <= {RES_W{1'b0}};
            end
        end else begin
            busy_r      <= busy_nxt_s;
            res_vld_r   <= capture_s;
            scan_done_r <= done_pulse_s;
            if (capture_s) begin
                res_r    <= spi_rd_s[RES_W-1:0];
                res_ch_r <= cap_ch_r;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture_s && (cap_ch_r == CH_W'(i))) begin
                    rf_r[i] <= spi_rd_s[RES_W-1:0];
                end
            end
        end
    end

    // Combinational result file read; out-of-range addresses read 0.
    always_comb begin
        rd_data = {RES_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            rd_data = (rd_ch == CH_W'(i)) ? rf_r[i] : rd_data;
        end
    end

    spi_mstr16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (launch_s),
        .cmd     (mk_cmd(launch_ch_s)),
        .done    (spi_done_s),
        .rd_data (spi_rd_s),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign busy      = busy_r;
    assign res       = res_r;
    assign res_ch    = res_ch_r;
    assign res_vld   = res_vld_r;
    assign scan_done = scan_done_r;

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Directed bench for a2d_scan_intf with a behavioural ADC128S returning 12'h100*ch + 12'h0AB.
// The continuous-mode scenario runs only when A2D_SCAN_CONT_EN is defined.
module tb_a2d_scan_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_scan = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic [2:0]  rd_ch = 3'd0;
    logic        MISO = 1'b0;
    logic        busy, res_vld, scan_done, SS_n, SCLK, MOSI;
    logic [11:0] res, rd_data;
    logic [2:0]  res_ch;
`ifdef A2D_SCAN_CONT_EN
    logic        cont = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    a2d_scan_intf #(.NUM_CH(8), .SCLK_DIV(32), .RES_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .strt_scan(strt_scan), .ch_mask(ch_mask),
        .busy(busy), .res(res), .res_ch(res_ch), .res_vld(res_vld), .scan_done(scan_done),
        .rd_ch(rd_ch), .rd_data(rd_data), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
`ifdef A2D_SCAN_CONT_EN
        , .cont(cont)
`endif
    );

    // ADC128S model: returns the result of the channel commanded in the previous complete frame.
    logic [15:0] adc_tx = 16'h0000;
    logic [15:0] adc_rx = 16'h0000;
    logic [2:0]  adc_ch = 3'd0;
    int          adc_bits = 0;
    always @(negedge SS_n) begin
        adc_tx   <= {4'h0, 12'h100 * {9'd0, adc_ch} + 12'h0AB};
        adc_bits <= 0;
    end
    always @(negedge SCLK) if (!SS_n) begin
        MISO   <= adc_tx[15];
        adc_tx <= {adc_tx[14:0], 1'b0};
    end
    always @(posedge SCLK) if (!SS_n) begin
        adc_rx   <= {adc_rx[14:0], MOSI};
        adc_bits <= adc_bits + 1;
    end
    always @(posedge SS_n) if (adc_bits == 16) adc_ch <= adc_rx[13:11];

    // Event monitor: frame starts, result strobes with their latency from SS_n rise, scan_done pulses.
    int          cyc = 0;
    int          frames = 0;
    int          vld_n = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    int          last_vld_cyc = 0;
    int          ss_rise_cyc = 0;
    int          busy_low_n = 0;
    logic        busy_watch = 1'b0;
    logic        ss_prev = 1'b1;
    logic [2:0]  vld_ch  [64];
    logic [11:0] vld_res [64];
    int          vld_lat [64];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge SS_n) frames <= frames + 1;
    always @(negedge clk) begin
        ss_prev <= SS_n;
        if (SS_n && !ss_prev) ss_rise_cyc <= cyc;
        if (res_vld) begin
            if (vld_n < 64) begin
                vld_ch[vld_n]  <= res_ch;
                vld_res[vld_n] <= res;
                vld_lat[vld_n] <= cyc - ss_rise_cyc;
            end
            vld_n        <= vld_n + 1;
            last_vld_cyc <= cyc;
        end
        if (scan_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (busy_watch && !busy) busy_low_n <= busy_low_n + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [7:0] m);
        step();
        strt_scan = 1'b1;
        ch_mask   = m;
        step();
        strt_scan = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (done_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++; if (SS_n !== 1'b1)      begin fails++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
        checks++; if (SCLK !== 1'b1)      begin fails++; $display("FAIL rst_sclk: got %b want 1", SCLK); end
        checks++; if (MOSI !== 1'b0)      begin fails++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
        checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (res !== 12'h000)    begin fails++; $display("FAIL rst_res: got %h want 000", res); end
        checks++; if (res_ch !== 3'd0)    begin fails++; $display("FAIL rst_res_ch: got %0d want 0", res_ch); end
        checks++; if (res_vld !== 1'b0)   begin fails++; $display("FAIL rst_res_vld: got %b want 0", res_vld); end
        checks++; if (scan_done !== 1'b0) begin fails++; $display("FAIL rst_scan_done: got %b want 0", scan_done); end
        for (int c = 0; c < 8; c++) begin
            rd_ch = 3'(c);
            #1;
            checks++; if (rd_data !== 12'h000) begin fails++; $display("FAIL rst_rf[%0d]: got %h want 000", c, rd_data); end
        end
    endtask

    task automatic test_single();
        int f0, v0, d0;
        bit ok;
        f0 = frames; v0 = vld_n; d0 = done_n;
        start_scan(8'h01);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_rise: got %b want 1", busy); end
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin fails++; $display("FAIL single_timeout: got no scan_done want scan_done"); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_fall: got %b want 0", busy); end
        checks++; if (frames - f0 != 2) begin fails++; $display("FAIL single_frames: got %0d want 2", frames - f0); end
        checks++; if (vld_n - v0 != 1) begin fails++; $display("FAIL single_vld_count: got %0d want 1", vld_n - v0); end
        checks++; if (vld_res[v0] !== 12'h0AB) begin fails++; $display("FAIL single_vld_res: got %h want 0AB", vld_res[v0]); end
        checks++; if (res !== 12'h0AB) begin fails++; $display("FAIL single_res: got %h want 0AB", res); end
        checks++; if (res_ch !== 3'd0) begin fails++; $display("FAIL single_res_ch: got %0d want 0", res_ch); end
        checks++; if (vld_lat[v0] != 1) begin fails++; $display("FAIL single_vld_lat: got %0d want 1", vld_lat[v0]); end
        checks++; if (done_cyc != last_vld_cyc + 1) begin fails++; $display("FAIL single_done_lat: got %0d want %0d", done_cyc, last_vld_cyc + 1); end
    endtask

    task automatic test_multi();
        int f0, v0, d0;
        bit ok;
        logic [2:0]  exp_ch  [4];
        logic [11:0] exp_res [4];
        logic [2:0]  zero_ch [4];
        exp_ch  = '{3'd0, 3'd2, 3'd5, 3'd7};
        exp_res = '{12'h0AB, 12'h2AB, 12'h5AB, 12'h7AB};
        zero_ch = '{3'd1, 3'd3, 3'd4, 3'd6};
        f0 = frames; v0 = vld_n; d0 = done_n;
        start_scan(8'hA5);
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin fails++; $display("FAIL multi_timeout: got no scan_done want scan_done"); end
        checks++; if (frames - f0 != 5) begin fails++; $display("FAIL multi_frames: got %0d want 5", frames - f0); end
        checks++; if (vld_n - v0 != 4) begin fails++; $display("FAIL multi_vld_count: got %0d want 4", vld_n - v0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vld_ch[v0+i] !== exp_ch[i]) begin fails++; $display("FAIL multi_ch[%0d]: got %0d want %0d", i, vld_ch[v0+i], exp_ch[i]); end
            checks++; if (vld_res[v0+i] !== exp_res[i]) begin fails++; $display("FAIL multi_res[%0d]: got %h want %h", i, vld_res[v0+i], exp_res[i]); end
            checks++; if (vld_lat[v0+i] != 1) begin fails++; $display("FAIL multi_lat[%0d]: got %0d want 1", i, vld_lat[v0+i]); end
        end
        checks++; if (done_cyc != last_vld_cyc + 1) begin fails++; $display("FAIL multi_done_lat: got %0d want %0d", done_cyc, last_vld_cyc + 1); end
        rd_ch = 3'd5;
        #1;
        checks++; if (rd_data !== 12'h5AB) begin fails++; $display("FAIL multi_rd5: got %h want 5AB", rd_data); end
        for (int i = 0; i < 4; i++) begin
            rd_ch = zero_ch[i];
            #1;
            checks++; if (rd_data !== 12'h000) begin fails++; $display("FAIL multi_rd_zero[%0d]: got %h want 000", zero_ch[i], rd_data); end
        end
    endtask

    task automatic test_zero_mask();
        int f0, d0;
        f0 = frames; d0 = done_n;
        start_scan(8'h00);
        checks++; if (scan_done !== 1'b1) begin fails++; $display("FAIL zero_done_pulse: got %b want 1", scan_done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b want 0", busy); end
        step();
        checks++; if (scan_done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %b want 0", scan_done); end
        repeat (100) step();
        checks++; if (frames != f0) begin fails++; $display("FAIL zero_frames: got %0d want 0", frames - f0); end
        checks++; if (done_n - d0 != 1) begin fails++; $display("FAIL zero_done_count: got %0d want 1", done_n - d0); end
    endtask

    task automatic test_ignore_start();
        int f0, v0, d0;
        bit ok;
        f0 = frames; v0 = vld_n; d0 = done_n;
        start_scan(8'h03);
        repeat (200) step();
        strt_scan = 1'b1;
        ch_mask   = 8'hF0;
        step();
        strt_scan = 1'b0;
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin fails++; $display("FAIL ignore_timeout: got no scan_done want scan_done"); end
        checks++; if (frames - f0 != 3) begin fails++; $display("FAIL ignore_frames: got %0d want 3", frames - f0); end
        checks++; if (vld_n - v0 != 2) begin fails++; $display("FAIL ignore_vld_count: got %0d want 2", vld_n - v0); end
        checks++; if (vld_ch[v0+1] !== 3'd1) begin fails++; $display("FAIL ignore_ch: got %0d want 1", vld_ch[v0+1]); end
        checks++; if (vld_res[v0+1] !== 12'h1AB) begin fails++; $display("FAIL ignore_res: got %h want 1AB", vld_res[v0+1]); end
        repeat (2000) step();
        checks++; if (done_n - d0 != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", done_n - d0); end
        ch_mask = 8'h00;
    endtask

    task automatic test_reset_mid();
        int f0, v0, d0;
        bit ok, seen;
        f0 = frames;
        seen = 1'b0;
        rd_ch = 3'd0;
        start_scan(8'hFF);
        for (int i = 0; i < 5000; i++) begin
            step();
            if (frames - f0 >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin fails++; $display("FAIL midrst_frame3_timeout: got %0d frames want 3", frames - f0); end
        repeat (100) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (SS_n !== 1'b1)      begin fails++; $display("FAIL midrst_ss_n: got %b want 1", SS_n); end
        checks++; if (SCLK !== 1'b1)      begin fails++; $display("FAIL midrst_sclk: got %b want 1", SCLK); end
        checks++; if (MOSI !== 1'b0)      begin fails++; $display("FAIL midrst_mosi: got %b want 0", MOSI); end
        checks++; if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (res !== 12'h000)    begin fails++; $display("FAIL midrst_res: got %h want 000", res); end
        checks++; if (rd_data !== 12'h000) begin fails++; $display("FAIL midrst_rf0: got %h want 000", rd_data); end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        v0 = vld_n; d0 = done_n; f0 = frames;
        start_scan(8'h81);
        wait_done(d0 + 1, ok);
        checks++; if (!ok) begin fails++; $display("FAIL midrst_rescan_timeout: got no scan_done want scan_done"); end
        checks++; if (frames - f0 != 3) begin fails++; $display("FAIL midrst_frames: got %0d want 3", frames - f0); end
        checks++; if (vld_res[v0] !== 12'h0AB) begin fails++; $display("FAIL midrst_res0: got %h want 0AB", vld_res[v0]); end
        checks++; if (vld_ch[v0+1] !== 3'd7) begin fails++; $display("FAIL midrst_ch1: got %0d want 7", vld_ch[v0+1]); end
        checks++; if (vld_res[v0+1] !== 12'h7AB) begin fails++; $display("FAIL midrst_res1: got %h want 7AB", vld_res[v0+1]); end
    endtask

`ifdef A2D_SCAN_CONT_EN
    task automatic test_cont();
        int f0, d0, b0;
        bit ok;
        f0 = frames; d0 = done_n;
        cont = 1'b1;
        start_scan(8'h03);
        b0 = busy_low_n;
        busy_watch = 1'b1;
        wait_done(d0 + 2, ok);
        checks++; if (!ok) begin fails++; $display("FAIL cont_two_scans_timeout: got %0d want 2", done_n - d0); end
        checks++; if (busy_low_n != b0) begin fails++; $display("FAIL cont_busy_held: got %0d low cycles want 0", busy_low_n - b0); end
        busy_watch = 1'b0;
        cont = 1'b0;
        wait_done(d0 + 3, ok);
        checks++; if (!ok) begin fails++; $display("FAIL cont_last_scan_timeout: got %0d want 3", done_n - d0); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_busy_fall: got %b want 0", busy); end
        repeat (2000) step();
        checks++; if (done_n - d0 != 3) begin fails++; $display("FAIL cont_done_count: got %0d want 3", done_n - d0); end
        checks++; if (frames - f0 != 9) begin fails++; $display("FAIL cont_frames: got %0d want 9", frames - f0); end
        checks++; if (res !== 12'h1AB) begin fails++; $display("FAIL cont_res: got %h want 1AB", res); end
        ch_mask = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero_mask();
        test_ignore_start();
        test_reset_mid();
`ifdef A2D_SCAN_CONT_EN
        test_cont();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
